// File: rtl/idu_issue_sb.sv
// idu_issue_sb: decode/issue stage with an instruction FIFO, the GPR file
// and a per-register pending-write scoreboard guarding RAW/WAW hazards.
module idu_issue_sb #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 2,
    parameter int PEND_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic [DATA_WIDTH-1:0] in_inst,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_pc,
    output logic [DATA_WIDTH-1:0] out_inst,
    output logic [DATA_WIDTH-1:0] out_rs1_data,
    output logic [DATA_WIDTH-1:0] out_rs2_data,
    output logic [ADDR_WIDTH-1:0] out_rd,
    output logic                  out_rd_wen,
    output logic                  out_illegal,
    input  logic                  wb_valid,
    input  logic                  wb_wen,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  flush,
    output logic                  sb_err
);

    localparam int NREG  = 1 << ADDR_WIDTH;
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [PTR_W:0]        FIFO_FULL = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0]      PTR_ONE   = PTR_W'(1);
    localparam logic [PEND_WIDTH-1:0] PEND_MAX  = '1;
    localparam logic [PEND_WIDTH-1:0] PEND_ONE  = PEND_WIDTH'(1);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    logic [DATA_WIDTH-1:0] fifo_pc_q   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_pc_d   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_inst_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_inst_d [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]        cnt_q, cnt_d;

    logic [DATA_WIDTH-1:0] gpr_q  [NREG];
    logic [DATA_WIDTH-1:0] gpr_d  [NREG];
    logic [PEND_WIDTH-1:0] pend_q [NREG];
    logic [PEND_WIDTH-1:0] pend_d [NREG];

    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_pc_q, out_pc_d;
    logic [DATA_WIDTH-1:0] out_inst_q, out_inst_d;
    logic [DATA_WIDTH-1:0] out_rs1_data_q, out_rs1_data_d;
    logic [DATA_WIDTH-1:0] out_rs2_data_q, out_rs2_data_d;
    logic [ADDR_WIDTH-1:0] out_rd_q, out_rd_d;
    logic                  out_rd_wen_q, out_rd_wen_d;
    logic                  out_illegal_q, out_illegal_d;
    logic                  sb_err_q, sb_err_d;

    logic                  head_valid;
    logic [DATA_WIDTH-1:0] head_pc, head_inst;
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [ADDR_WIDTH-1:0] rs1, rs2, rd;
    logic                  use_rs1, use_rs2, writes, illegal;
    logic                  rd_wen;
    logic                  wb_we, byp1, byp2;
    logic                  haz1, haz2, haz_rd, hazard;
    logic                  issue, push, err_hit;
    logic [DATA_WIDTH-1:0] rs1_data, rs2_data;

    assign head_valid = (cnt_q != '0);
    assign in_ready   = (cnt_q != FIFO_FULL);
    assign head_pc    = fifo_pc_q[rd_ptr_q];
    assign head_inst  = fifo_inst_q[rd_ptr_q];
    assign opcode     = head_inst[6:0];
    assign funct3     = head_inst[14:12];
    assign rd         = head_inst[7 +: ADDR_WIDTH];
    assign rs1        = head_inst[15 +: ADDR_WIDTH];
    assign rs2        = head_inst[20 +: ADDR_WIDTH];

    // Classify the head opcode into operand reads and destination write.
    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        writes  = 1'b0;
        illegal = 1'b0;
        unique case (opcode)
            OPC_LOAD:   begin use_rs1 = 1'b1; writes = 1'b1; end
            OPC_OP_IMM: begin use_rs1 = 1'b1; writes = 1'b1; end
            OPC_AUIPC:  writes = 1'b1;
            OPC_STORE:  begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OPC_OP:     begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                writes  = 1'b1;
            end
            OPC_LUI:    writes = 1'b1;
            OPC_BRANCH: begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OPC_JALR:   begin use_rs1 = 1'b1; writes = 1'b1; end
            OPC_JAL:    writes = 1'b1;
            OPC_SYSTEM: begin
                use_rs1 = 1'b1;
                writes  = (funct3 != 3'd0);
            end
            default:    illegal = 1'b1;
        endcase
    end

    assign rd_wen = writes && (rd != '0);
    assign wb_we  = wb_valid && wb_wen && (wb_addr != '0);
    assign byp1   = wb_valid && wb_wen && (wb_addr == rs1);
    assign byp2   = wb_valid && wb_wen && (wb_addr == rs2);

    // A last outstanding write landing this cycle is forwarded, not waited on.
    assign haz1 = use_rs1 && (rs1 != '0) && (pend_q[rs1] != '0)
                  && !(byp1 && pend_q[rs1] == PEND_ONE);
    assign haz2 = use_rs2 && (rs2 != '0) && (pend_q[rs2] != '0)
                  && !(byp2 && pend_q[rs2] == PEND_ONE);
    assign haz_rd = rd_wen && (pend_q[rd] == PEND_MAX);
    assign hazard = haz1 || haz2 || haz_rd;

    assign issue = head_valid && !hazard
                   && (!out_valid_q || out_ready) && !flush;
    assign push  = in_valid && in_ready && !flush;

    assign rs1_data = (use_rs1 && rs1 != '0)
                      ? (byp1 ? wb_data : gpr_q[rs1]) : '0;
    assign rs2_data = (use_rs2 && rs2 != '0)
                      ? (byp2 ? wb_data : gpr_q[rs2]) : '0;

    // Instruction buffer: circular FIFO, flush empties it outright.
    always_comb begin
        fifo_pc_d   = fifo_pc_q;
        fifo_inst_d = fifo_inst_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        cnt_d       = cnt_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                fifo_pc_d[wr_ptr_q]   = in_pc;
                fifo_inst_d[wr_ptr_q] = in_inst;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (issue) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            cnt_d = cnt_q + (PTR_W+1)'(push) - (PTR_W+1)'(issue);
        end
    end

    // Register file write from the writeback port; x0 stays zero.
    always_comb begin
        gpr_d = gpr_q;
        if (wb_we) begin
            gpr_d[wb_addr] = wb_data;
        end
    end

    // Pending counters: reserve on issue, release on writeback or flush.
    always_comb begin
        err_hit = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            logic                  inc, dec_wb, dec_fl;
            logic [PEND_WIDTH:0]   sum, sub;
            inc    = issue && rd_wen && (rd == ADDR_WIDTH'(i));
            dec_wb = wb_we && (wb_addr == ADDR_WIDTH'(i));
            dec_fl = flush && out_valid_q && out_rd_wen_q
                     && (out_rd_q == ADDR_WIDTH'(i));
            sum = {1'b0, pend_q[i]} + (PEND_WIDTH+1)'(inc);
            sub = (PEND_WIDTH+1)'(dec_wb) + (PEND_WIDTH+1)'(dec_fl);
            pend_d[i] = (sum >= sub) ? PEND_WIDTH'(sum - sub) : '0;
            if (dec_wb && pend_q[i] == '0) begin
                err_hit = 1'b1;
            end
        end
        sb_err_d = sb_err_q || err_hit;
    end

    // Issue register: load on issue, drop when consumed or flushed.
    always_comb begin
        out_valid_d    = out_valid_q;
        out_pc_d       = out_pc_q;
        out_inst_d     = out_inst_q;
        out_rs1_data_d = out_rs1_data_q;
        out_rs2_data_d = out_rs2_data_q;
        out_rd_d       = out_rd_q;
        out_rd_wen_d   = out_rd_wen_q;
        out_illegal_d  = out_illegal_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (issue) begin
            out_valid_d    = 1'b1;
            out_pc_d       = head_pc;
            out_inst_d     = head_inst;
            out_rs1_data_d = rs1_data;
            out_rs2_data_d = rs2_data;
            out_rd_d       = rd;
            out_rd_wen_d   = rd_wen;
            out_illegal_d  = illegal;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fifo_pc_q      <= '{default: '0};
            fifo_inst_q    <= '{default: '0};
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            cnt_q          <= '0;
            gpr_q          <= '{default: '0};
            pend_q         <= '{default: '0};
            out_valid_q    <= 1'b0;
            out_pc_q       <= '0;
            out_inst_q     <= '0;
            out_rs1_data_q <= '0;
            out_rs2_data_q <= '0;
            out_rd_q       <= '0;
            out_rd_wen_q   <= 1'b0;
            out_illegal_q  <= 1'b0;
            sb_err_q       <= 1'b0;
        end else begin
            fifo_pc_q      <= fifo_pc_d;
            fifo_inst_q    <= fifo_inst_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            cnt_q          <= cnt_d;
            gpr_q          <= gpr_d;
            pend_q         <= pend_d;
            out_valid_q    <= out_valid_d;
            out_pc_q       <= out_pc_d;
            out_inst_q     <= out_inst_d;
            out_rs1_data_q <= out_rs1_data_d;
            out_rs2_data_q <= out_rs2_data_d;
            out_rd_q       <= out_rd_d;
            out_rd_wen_q   <= out_rd_wen_d;
            out_illegal_q  <= out_illegal_d;
            sb_err_q       <= sb_err_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_pc       = out_pc_q;
    assign out_inst     = out_inst_q;
    assign out_rs1_data = out_rs1_data_q;
    assign out_rs2_data = out_rs2_data_q;
    assign out_rd       = out_rd_q;
    assign out_rd_wen   = out_rd_wen_q;
    assign out_illegal  = out_illegal_q;
    assign sb_err       = sb_err_q;

endmodule

// File: tb/tb_idu_issue_sb.sv
// tb_idu_issue_sb: directed scenarios plus randomized traffic, checked
// each cycle against a queue/array model of the issue stage.
module tb_idu_issue_sb;

    localparam int FD   = 2;
    localparam int PMAX = 3;

    logic        clk, rst;
    logic        in_valid, in_ready;
    logic [31:0] in_pc, in_inst;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_inst, out_rs1_data, out_rs2_data;
    logic [4:0]  out_rd;
    logic        out_rd_wen, out_illegal;
    logic        wb_valid, wb_wen;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush, sb_err;

    idu_issue_sb dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
        .out_rd(out_rd), .out_rd_wen(out_rd_wen),
        .out_illegal(out_illegal),
        .wb_valid(wb_valid), .wb_wen(wb_wen),
        .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush), .sb_err(sb_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        fq[$];
    logic [31:0] m_regs [32];
    int          m_pend [32];
    logic        m_ov, m_rdw, m_ill, m_err;
    logic [31:0] m_pc, m_inst, m_rs1, m_rs2;
    logic [4:0]  m_rd;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void dec(input logic [31:0] i, output bit u1,
                                output bit u2, output bit w, output bit il);
        u1 = 0; u2 = 0; w = 0; il = 0;
        case (i[6:0])
            7'h03: begin u1 = 1; w = 1; end
            7'h13: begin u1 = 1; w = 1; end
            7'h17: w = 1;
            7'h23: begin u1 = 1; u2 = 1; end
            7'h33: begin u1 = 1; u2 = 1; w = 1; end
            7'h37: w = 1;
            7'h63: begin u1 = 1; u2 = 1; end
            7'h67: begin u1 = 1; w = 1; end
            7'h6f: w = 1;
            7'h73: begin u1 = 1; w = (i[14:12] != 3'd0); end
            default: il = 1;
        endcase
    endfunction

    task automatic model_step();
        logic [31:0] hi, d1, d2;
        logic [4:0]  r1, r2, rd;
        bit u1, u2, w, il, rdw, hv, haz, iss, wbw, pu;
        int np [32];
        int sz;
        if (!rst) begin
            fq.delete();
            m_regs = '{default: 32'h0};
            m_pend = '{default: 0};
            m_ov = 0; m_rdw = 0; m_ill = 0; m_err = 0;
            m_pc = 0; m_inst = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
            return;
        end
        sz = fq.size();
        hv = (sz > 0);
        hi = hv ? fq[0].inst : 32'h0;
        dec(hi, u1, u2, w, il);
        r1 = hi[19:15];
        r2 = hi[24:20];
        rd = hi[11:7];
        rdw = w && (rd != 0);
        wbw = wb_valid && wb_wen && (wb_addr != 0);
        haz = 0;
        if (u1 && r1 != 0 && m_pend[r1] != 0 &&
            !(wb_valid && wb_wen && wb_addr == r1 && m_pend[r1] == 1))
            haz = 1;
        if (u2 && r2 != 0 && m_pend[r2] != 0 &&
            !(wb_valid && wb_wen && wb_addr == r2 && m_pend[r2] == 1))
            haz = 1;
        if (rdw && m_pend[rd] == PMAX) haz = 1;
        iss = hv && !haz && (!m_ov || out_ready) && !flush;
        d1 = (u1 && r1 != 0) ? ((wbw && wb_addr == r1) ? wb_data : m_regs[r1]) : 0;
        d2 = (u2 && r2 != 0) ? ((wbw && wb_addr == r2) ? wb_data : m_regs[r2]) : 0;
        np = m_pend;
        if (iss && rdw) np[rd]++;
        if (wbw) begin
            if (m_pend[wb_addr] == 0) m_err = 1;
            np[wb_addr]--;
        end
        if (flush && m_ov && m_rdw) np[m_rd]--;
        for (int k = 0; k < 32; k++) if (np[k] < 0) np[k] = 0;
        m_pend = np;
        if (wbw) m_regs[wb_addr] = wb_data;
        pu = in_valid && (sz < FD);
        if (flush) begin
            fq.delete();
            m_ov = 0;
        end else begin
            if (iss) begin
                m_ov = 1; m_pc = fq[0].pc; m_inst = hi;
                m_rs1 = d1; m_rs2 = d2; m_rd = rd; m_rdw = rdw; m_ill = il;
                void'(fq.pop_front());
            end else if (out_ready) begin
                m_ov = 0;
            end
            if (pu) fq.push_back({in_pc, in_inst});
        end
    endtask

    // Compare registered outputs mid-cycle, then advance the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", in_ready, (fq.size() < FD));
            chk("out_valid", out_valid, m_ov);
            chk("out_pc", out_pc, m_pc);
            chk("out_inst", out_inst, m_inst);
            chk("out_rs1_data", out_rs1_data, m_rs1);
            chk("out_rs2_data", out_rs2_data, m_rs2);
            chk("out_rd", out_rd, m_rd);
            chk("out_rd_wen", out_rd_wen, m_rdw);
            chk("out_illegal", out_illegal, m_ill);
            chk("sb_err", sb_err, m_err);
        end
        model_step();
    end

    logic [6:0] opc_tab [11] = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37,
                                 7'h63, 7'h67, 7'h6f, 7'h73, 7'h0f};

    function automatic logic [31:0] rand_inst();
        logic [31:0] i;
        i = $urandom;
        i[6:0]   = opc_tab[$urandom_range(0, 10)];
        i[11:7]  = 5'($urandom_range(0, 7));
        i[14:12] = 3'($urandom_range(0, 7));
        i[19:15] = 5'($urandom_range(0, 7));
        i[24:20] = 5'($urandom_range(0, 7));
        return i;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; flush = 0; wb_valid = 0; wb_wen = 0; out_ready = 1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] inst);
        bit done = 0;
        in_valid = 1; in_pc = pc; in_inst = inst;
        for (int k = 0; k < 50 && !done; k++) begin
            done = in_ready;
            tick();
        end
        in_valid = 0;
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL push_timeout: in_ready stuck low, inst %h", inst);
        end
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_valid = 1; wb_wen = 1; wb_addr = a; wb_data = d;
        tick();
        wb_valid = 0; wb_wen = 0;
    endtask

    task automatic drain();
        idle();
        repeat (3) begin
            repeat (4) tick();
            for (int r = 1; r < 32; r++)
                for (int k = 0; k < 8 && m_pend[r] > 0; k++)
                    wb(5'(r), $urandom);
        end
        repeat (4) tick();
    endtask

    initial begin
        int cand[$];
        rst = 0; in_valid = 0; in_pc = 0; in_inst = 0; out_ready = 1;
        wb_valid = 0; wb_wen = 0; wb_addr = 0; wb_data = 0; flush = 0;
        tick(); tick();
        chk_en = 1;
        tick();
        rst = 1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_sb_err", sb_err, 0);
        chk("rst_out_inst", out_inst, 0);
        chk("rst_out_rs1", out_rs1_data, 0);

        // RAW stall then bypass on writeback
        push(32'h100, 32'h00500093);
        push(32'h104, 32'h00108133);
        chk("t1_addi_valid", out_valid, 1);
        chk("t1_addi_inst", out_inst, 32'h00500093);
        repeat (3) tick();
        chk("t1_stalled", out_valid, 0);
        wb(5'd1, 32'd5);
        chk("t1_add_valid", out_valid, 1);
        chk("t1_add_inst", out_inst, 32'h00108133);
        chk("t1_add_rs1", out_rs1_data, 32'd5);
        chk("t1_add_rs2", out_rs2_data, 32'd5);
        chk("t1_add_rd", out_rd, 5'd2);
        drain();

        // same-cycle writeback bypass of last pending write
        push(32'h200, 32'h00000193);
        push(32'h204, 32'h00018233);
        wb(5'd3, 32'h1234);
        chk("t2_inst", out_inst, 32'h00018233);
        chk("t2_rs1", out_rs1_data, 32'h1234);
        chk("t2_rs2", out_rs2_data, 0);
        drain();

        // WAW overflow: fourth writer of x5 waits for one writeback
        push(32'h300, 32'h00100293);
        push(32'h304, 32'h00200293);
        push(32'h308, 32'h00300293);
        push(32'h30c, 32'h00400293);
        tick(); tick();
        chk("t3_waw_stall", out_valid, 0);
        wb(5'd5, 32'h55);
        chk("t3_waw_still", out_valid, 0);
        tick();
        chk("t3_waw_issue", out_valid, 1);
        chk("t3_waw_inst", out_inst, 32'h00400293);
        drain();

        // backpressure: fill FIFO, hold output, then drain in order
        out_ready = 0;
        push(32'h400, 32'h00001537);
        push(32'h404, 32'h000025b7);
        push(32'h408, 32'h00003637);
        chk("t4_full", in_ready, 0);
        repeat (3) tick();
        chk("t4_hold_inst", out_inst, 32'h00001537);
        chk("t4_hold_pc", out_pc, 32'h400);
        out_ready = 1;
        tick();
        chk("t4_drain1", out_inst, 32'h000025b7);
        tick();
        chk("t4_drain2", out_inst, 32'h00003637);
        tick();
        chk("t4_empty", out_valid, 0);
        drain();

        // flush with live issue register and one buffered entry
        out_ready = 0;
        push(32'h500, 32'h00000393);
        push(32'h504, 32'h000016b7);
        chk("t5_pre_rd", out_rd, 5'd7);
        flush = 1;
        tick();
        flush = 0;
        chk("t5_flush_valid", out_valid, 0);
        chk("t5_flush_ready", in_ready, 1);
        out_ready = 1;
        push(32'h508, 32'h00038433);
        tick();
        chk("t5_no_stall", out_valid, 1);
        chk("t5_inst", out_inst, 32'h00038433);
        drain();

        // writeback with no reservation, then reset during a stall
        wb(5'd9, 32'hCAFE0009);
        chk("t6_sb_err", sb_err, 1);
        push(32'h600, 32'h00048733);
        tick();
        chk("t6_x9_data", out_rs1_data, 32'hCAFE0009);
        push(32'h604, 32'h00500093);
        push(32'h608, 32'h00108133);
        tick(); tick();
        chk("t6_stall", out_valid, 0);
        rst = 0;
        tick(); tick();
        rst = 1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_ready", in_ready, 1);
        chk("t6_rst_err", sb_err, 0);
        chk("t6_rst_inst", out_inst, 0);
        push(32'h610, 32'h00048733);
        tick();
        chk("t6_x9_cleared", out_rs1_data, 0);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            in_pc     = $urandom;
            in_inst   = rand_inst();
            out_ready = ($urandom_range(0, 99) < 70);
            flush     = ($urandom_range(0, 99) < 3);
            cand.delete();
            for (int r = 1; r < 32; r++) if (m_pend[r] > 0) cand.push_back(r);
            wb_data = $urandom;
            wb_addr = 5'($urandom_range(0, 31));
            if (cand.size() > 0 && $urandom_range(0, 99) < 45) begin
                wb_valid = 1; wb_wen = 1;
                wb_addr = 5'(cand[$urandom_range(0, cand.size() - 1)]);
            end else if ($urandom_range(0, 99) < 10) begin
                wb_valid = 1; wb_wen = 0;
            end else if ($urandom_range(0, 99) < 5) begin
                wb_valid = 1; wb_wen = 1; wb_addr = 0;
            end else begin
                wb_valid = 0; wb_wen = $urandom_range(0, 1);
            end
            tick();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
